// File: rtl/comparator_2.sv
`default_nettype none
// ============================================================================
// Module   : comparator_2
// Brief    : Pipelined soft-threshold blend-weight generator for the CFA
//            demosaic datapath. Maps an activity metric onto a 0..FS weight:
//            0 at or below blend_th0, FS at or above blend_th1, and a linear
//            ramp in between, computed by a restoring divider.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - a / blend_th0 / blend_th1 hold a sample this cycle
//            a          - unsigned metric
//            blend_th0  - lower threshold
//            blend_th1  - upper threshold
//            out_valid  - out holds a result this cycle
//            out        - unsigned blend weight
// Latency  : W+2 register stages (1 front end, W divider, 1 output mux)
// Revision : 1.0 - initial release
// ============================================================================
module comparator_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] blend_th0,
    input  logic [W-1:0] blend_th1,
    output logic         out_valid,
    output logic [W-1:0] out
);

    localparam logic [W-1:0] c_FS  = {W{1'b1}};
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- front end
    logic           w_lo;
    logic           w_hi;
    logic           w_ramp;
    logic [W-1:0]   w_diff;
    logic [2*W-1:0] w_num;
    logic [W-1:0]   w_den;

    // The a <= th0 test takes priority, so with th1 <= th0 any a above th0
    // also satisfies a >= th1 and the ramp is empty: a hard threshold falls
    // out naturally.
    assign w_lo   = (a <= blend_th0);
    assign w_hi   = (a >= blend_th1);
    assign w_ramp = !w_lo && !w_hi;
    assign w_diff = a - blend_th0;

    // (a - th0) * (2^W - 1) as a shift-and-subtract. Outside the ramp the
    // divider is fed 0 / 1 so it never sees a zero divisor.
    assign w_num = w_ramp ? ({w_diff, {W{1'b0}}} - {{W{1'b0}}, w_diff}) : '0;
    assign w_den = w_ramp ? (blend_th1 - blend_th0) : c_ONE;

    // ---------------------------------------------------------- pipeline state
    // Index 0 is the front-end stage; index s (1..W) is divider stage s,
    // which resolves quotient bit W-s.
    logic           r_vld [0:W];
    logic           r_lo  [0:W];
    logic           r_hi  [0:W];
    logic [2*W-1:0] r_rem [0:W-1];
    logic [W-1:0]   r_den [0:W-1];
    logic [W-1:0]   r_quo [1:W];
    logic           r_out_vld;
    logic [W-1:0]   r_out;

    logic [W-1:0]   w_q_nxt   [1:W];
    logic [2*W-1:0] w_rem_nxt [1:W-1];

    // Restoring division: because a - th0 < D the numerator is below D*2^W,
    // so subtracting D<<b from MSB to LSB yields a W-bit quotient exactly.
    for (genvar s = 1; s <= W; s++) begin : g_div
        localparam int c_B = W - s;
        logic [2*W-1:0] w_dsh;
        logic           w_ge;

        assign w_dsh = {{W{1'b0}}, r_den[s-1]} << c_B;
        assign w_ge  = (r_rem[s-1] >= w_dsh);

        if (s == 1) begin : g_first
            assign w_q_nxt[s] = {{(W-1){1'b0}}, w_ge} << c_B;
        end else begin : g_rest
            assign w_q_nxt[s] = r_quo[s-1] | ({{(W-1){1'b0}}, w_ge} << c_B);
        end

        if (s < W) begin : g_rem
            assign w_rem_nxt[s] = w_ge ? (r_rem[s-1] - w_dsh) : r_rem[s-1];
        end
    end

    // Valid bits always advance; data registers load only with a valid
    // sample so the output holds its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= W; s++) begin
                r_vld[s] <= 1'b0;
                r_lo[s]  <= 1'b0;
                r_hi[s]  <= 1'b0;
            end
            for (int s = 0; s < W; s++) begin
                r_rem[s] <= '0;
                r_den[s] <= '0;
            end
            for (int s = 1; s <= W; s++) begin
                r_quo[s] <= '0;
            end
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_lo[0]  <= w_lo;
                r_hi[0]  <= w_hi;
                r_rem[0] <= w_num;
                r_den[0] <= w_den;
            end

            for (int s = 1; s <= W; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_lo[s]  <= r_lo[s-1];
                    r_hi[s]  <= r_hi[s-1];
                    r_quo[s] <= w_q_nxt[s];
                end
            end

            for (int s = 1; s < W; s++) begin
                if (r_vld[s-1]) begin
                    r_rem[s] <= w_rem_nxt[s];
                    r_den[s] <= r_den[s-1];
                end
            end

            r_out_vld <= r_vld[W];
            if (r_vld[W]) begin
                r_out <= r_lo[W] ? '0 : (r_hi[W] ? c_FS : r_quo[W]);
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_comparator_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_2
// Brief    : Scoreboard bench for comparator_2. Stimulus pushes the expected
//            weight and arrival cycle; an independent monitor pops on every
//            out_valid and checks value, latency and hold behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] blend_th0;
    logic [7:0] blend_th1;
    logic       out_valid;
    logic [7:0] out;

    typedef struct {
        logic [7:0] v;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] last_out = 8'd0;

    comparator_2 #(.W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .blend_th0 (blend_th0),
        .blend_th1 (blend_th1),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] ref_w(input logic [7:0] av, input logic [7:0] t0,
                                         input logic [7:0] t1);
        int n;
        int d;
        if (av <= t0) return 8'd0;
        if (av >= t1) return 8'd255;
        n = (int'(av) - int'(t0)) * 255;
        d = int'(t1) - int'(t0);
        return 8'(n / d);
    endfunction

    // Sample captured at the next edge (cyc+1) appears after edge cyc+10.
    task automatic send(input logic [7:0] av, input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] exp_v);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        a         = av;
        blend_th0 = t0;
        blend_th1 = t1;
        e.v       = exp_v;
        e.cyc     = cyc + 10;
        sb.push_back(e);
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = 8'($urandom);
        blend_th0 = 8'($urandom);
        blend_th1 = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            n_chk++;
            if (out_valid !== 1'b0 || out !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state: out_valid=%b out=%0d, required 0/0", out_valid, out);
            end
            last_out = 8'd0;
        end else if (out_valid === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: out=%0d at cycle %0d, none pending", out, cyc);
            end else begin
                e = sb.pop_front();
                if (out !== e.v || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL result: out=%0d at cycle %0d, required %0d at cycle %0d",
                             out, cyc, e.v, e.cyc);
                end
            end
            last_out = out;
        end else begin
            n_chk++;
            if (out_valid !== 1'b0 || out !== last_out) begin
                n_fail++;
                $display("FAIL bubble_hold: out_valid=%b out=%0d, required 0/%0d",
                         out_valid, out, last_out);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] av;

        // Reset held with live, valid-tagged random inputs
        rst_n    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a         = 8'($urandom);
            blend_th0 = 8'($urandom);
            blend_th1 = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Ramp, lower side
        send(8'd0,   8'd10, 8'd240, 8'd0);
        send(8'd10,  8'd10, 8'd240, 8'd0);
        send(8'd15,  8'd10, 8'd240, 8'd5);
        send(8'd100, 8'd10, 8'd240, 8'd99);
        send(8'd120, 8'd10, 8'd240, 8'd121);
        // Ramp, upper side
        send(8'd220, 8'd10, 8'd240, 8'd232);
        send(8'd239, 8'd10, 8'd240, 8'd253);
        send(8'd240, 8'd10, 8'd240, 8'd255);
        send(8'd241, 8'd10, 8'd240, 8'd255);
        send(8'd250, 8'd10, 8'd240, 8'd255);
        // a = th0+1 -> floor(255/230)
        send(8'd11,  8'd10, 8'd240, 8'd1);
        // Degenerate thresholds
        send(8'd100, 8'd100, 8'd100, 8'd0);
        send(8'd101, 8'd100, 8'd100, 8'd255);
        send(8'd150, 8'd200, 8'd50,  8'd0);
        send(8'd201, 8'd200, 8'd50,  8'd255);
        // Full-range ramp is the identity
        send(8'd77,  8'd0, 8'd255, 8'd77);
        send(8'd254, 8'd0, 8'd255, 8'd254);
        send(8'd1,   8'd0, 8'd255, 8'd1);
        bubble();
        drain();

        // Streaming, thresholds changing every cycle, random bubbles
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
            end else begin
                t0 = 8'($urandom);
                t1 = 8'($urandom);
                av = 8'($urandom);
                send(av, t0, t1, ref_w(av, t0, t1));
            end
        end
        bubble();
        drain();

        // Leave a non-zero held output, then reset with 5 samples in flight
        send(8'd200, 8'd0, 8'd255, 8'd200);
        bubble();
        drain();
        send(8'd30,  8'd10, 8'd240, 8'd22);
        send(8'd60,  8'd10, 8'd240, 8'd55);
        send(8'd90,  8'd10, 8'd240, 8'd88);
        send(8'd130, 8'd10, 8'd240, 8'd133);
        send(8'd170, 8'd10, 8'd240, 8'd177);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b out=%0d, required 0/0", out_valid, out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pipeline keeps working and nothing of the discarded batch emerges
        for (int i = 0; i < 12; i++) bubble();
        send(8'd125, 8'd10, 8'd240, 8'd127);
        send(8'd5,   8'd10, 8'd240, 8'd0);
        bubble();
        drain();
        for (int i = 0; i < 4; i++) bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comparator_2.md
Name: comparator_2

Overview:
- Pipelined soft-threshold blend-weight generator for the CFA demosaic datapath.
- Maps an 8-bit activity/edge metric `a` onto a 0..255 blend weight using two programmable thresholds:
  - at or below `blend_th0` the weight is 0,
  - at or above `blend_th1` the weight is full scale,
  - between them the weight ramps linearly.
- Accepts one sample per clock with a fixed latency. Downstream blend multipliers consume `out`.

Parameters:
- W, 8, data width of `a`, both thresholds and `out`. Full-scale value is FS = 2^W-1.
- LAT, W+2 (derived, not overridable), pipeline latency in clocks.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  marks `a` and both thresholds as a valid sample this cycle.
- a  input  W  unsigned metric to map.
- blend_th0  input  W  lower threshold, unsigned.
- blend_th1  input  W  upper threshold, unsigned.
- out_valid  output  1  `out` holds a valid result this cycle.
- out  output  W  unsigned blend weight.

Behaviour:
- Reset: while rst_n=0, every pipeline register clears asynchronously, so out=0 and out_valid=0.
  - Reset asserted mid-stream discards all in-flight samples; none emerge after release.
- Thresholds are sampled per sample together with `a`, so thresholds may change every cycle. Each result uses the thresholds captured with its own `a`.
- Function, with D = th1 - th0:
  - if a <= th0: out = 0. This check has priority over all others.
  - else if a >= th1: out = FS.
  - else: out = floor((a - th0) * FS / D). Unsigned arithmetic, truncating, no rounding.
- Degenerate thresholds (th1 <= th0): the ramp is empty. The result is a hard threshold, out = (a <= th0) ? 0 : FS. The divider is never exercised with D = 0.
- Quotient range: a - th0 < D, so the quotient is always < 2^W. No saturation logic is needed; out never exceeds FS - 1 in the ramp region.
- Pipeline structure:
  - Stage 1 registers the compare flags (lo, hi), numerator N = (a-th0)*FS (2W bits) and D.
  - Stages 2..W+1 form a restoring divider, one quotient bit per stage, MSB first.
  - Stage W+2 registers the final mux of 0 / FS / quotient into `out`.
- Latency: a sample presented with in_valid=1 at rising edge k appears on `out` with out_valid=1 after rising edge k+LAT-1. For W=8 that is exactly 10 register stages.
- Throughput: one sample per clock. There is no back-pressure and no stall; the pipeline always advances.
- in_valid=0 bubbles propagate as out_valid=0. During a bubble, `out` holds its last valid value (the data registers are enabled by the stage valid bits).
- Boundaries:
  - a = th0 gives 0.
  - a = th1 gives FS.
  - a = th0+1 gives floor(FS/D).
  - th0 = 0 and th1 = FS gives the identity-like ramp floor(a*FS/FS) = a.

Test Plan:
- Reset: hold rst_n=0 with random inputs and in_valid=1 -> out=0 and out_valid=0 throughout. Release -> first out_valid exactly 10 cycles after the first sampled input.
- th0=10, th1=240, a = 0, 10, 15, 100, 120 -> out = 0, 0, 5, 99, 121. Each result must be tagged by out_valid at latency 10.
- th0=10, th1=240, a = 220, 239, 240, 241, 250 -> out = 232, 253, 255, 255, 255.
- Degenerate: th0=100, th1=100 with a = 100, 101 -> out = 0, 255. Also th0=200, th1=50 with a = 150, 201 -> out = 0, 255.
- Streaming: back-to-back samples each cycle with thresholds changing every cycle, plus randomly inserted in_valid=0 bubbles -> output sequence matches the reference formula sample-for-sample, bubbles reproduced in out_valid, and `out` holds during bubbles.
- Mid-stream reset: assert rst_n=0 for 1 cycle while 5 samples are in flight -> out and out_valid drop immediately and none of those 5 samples ever appear.
